pairing_cmd_sequencer: RTL and testbench
========================================

Name: pairing_cmd_sequencer

Overview:
- Upstream controller for the calculation core.
- Streams input coordinate words into the core RAM, then fetches commands from an external program memory.
- Issues each command to the core and waits for its finished flag.
- After the END command, reads result words back out of the core RAM and emits them as a valid-qualified stream.

Parameters:
WORD_SIZE, 256, data word width (matches core)
RAM_ADDR_SIZE, 8, core RAM address width
CMD_SIZE, 32, command width; mode field = CMD_SIZE-1 : 3*RAM_ADDR_SIZE
IM_SIZE, 2, core input-mode width
IM_IDLE, 0, input-mode value that is none of the three below
IM_LOAD, 1, value of `INPUT_COORD_CORE
IM_EXEC, 2, value of `EXEC_CORE
IM_REF, 3, value of `REF_RESULT
PC_SIZE, 10, program address width
N_IN, 4, input beats (two words each)
IN_BASE, 0, first core RAM address loaded
N_OUT, 6, output beats (two words each)
OUT_BASE, 64, first core RAM address read back
TIMEOUT, 65535, max cycles waiting for core_finished per command

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; accepted only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the last output beat is emitted
error  out  1  sticky; set on timeout or program overrun; cleared by the next accepted start
in_valid  in  1  input beat valid
in_ready  out  1  high only in LOAD
in_data1, in_data2  in  WORD_SIZE  input word pair
prog_addr  out  PC_SIZE  program memory address
prog_data  in  CMD_SIZE  program word, valid 1 cycle after prog_addr
core_inputmode  out  IM_SIZE  drives I_INPUTMODE
core_cmd  out  CMD_SIZE  drives top_cmd
core_waddr1, core_waddr2  out  RAM_ADDR_SIZE  drive I_WADDR1/2
core_wdata1, core_wdata2  out  WORD_SIZE  drive I_WDATA1/2
core_raddr1, core_raddr2  out  RAM_ADDR_SIZE  drive I_RADDR1/2
core_out1, core_out2  in  WORD_SIZE  core outdata1/2 (combinational read)
core_finished  in  1  core finished_flag
out_valid  out  1  result beat valid
out_data1, out_data2  out  WORD_SIZE  result word pair

Behaviour:
- Reset (async, rst=1): state=IDLE, pc=0, beat counters=0, wait counter=0.
  - All outputs 0 except core_inputmode=IM_IDLE.
  - error=0, core_cmd=0.
  - rst mid-operation aborts immediately; no partial write completes after rst asserts.
- IDLE:
  - core_inputmode=IM_IDLE, core_cmd=0.
  - start -> LOAD; clears error, pc and counters.
  - start in any other state is ignored.
- LOAD:
  - core_inputmode=IM_LOAD, in_ready=1.
  - Beat k is accepted when in_valid&in_ready. The beat is combinationally forwarded:
    - core_waddr1=IN_BASE+2k, core_waddr2=IN_BASE+2k+1
    - core_wdata = in_data
    - the core writes on the same clock edge.
  - When no beat is accepted, waddr/wdata are 0 and core_inputmode drops to IM_IDLE for that cycle, so the core does not write.
  - After beat N_IN-1 is accepted -> FETCH.
  - Addresses are computed modulo 2^RAM_ADDR_SIZE (wrap, no error).
- FETCH: prog_addr=pc held for 1 cycle -> ISSUE.
- ISSUE:
  - Latch prog_data into core_cmd.
  - Mode field all ones = END -> READ; core_cmd stays 0.
  - Otherwise -> WAIT, wait counter=0.
- WAIT:
  - core_inputmode=IM_EXEC, core_cmd held stable.
  - core_finished=1 -> GAP.
  - Counter reaching TIMEOUT first -> error=1, IDLE.
  - core_finished sampled in the same cycle the counter hits TIMEOUT: finished wins.
- GAP:
  - One cycle with core_inputmode=IM_IDLE, core_cmd=0, so the core returns to its state 0.
  - pc+1; if pc was 2^PC_SIZE-1 -> error=1, IDLE (program overrun). Otherwise -> FETCH.
- READ:
  - core_inputmode=IM_REF, core_raddr1=OUT_BASE+2k, core_raddr2=OUT_BASE+2k+1.
  - core_out is registered into out_data, so out_valid for beat k rises the cycle after its address is presented.
  - One beat per cycle, no backpressure.
  - After address N_OUT-1 is issued -> DONE.
- DONE:
  - Last beat's out_valid=1, done=1 for exactly this cycle -> IDLE.
- Per-command cost: 2 cycles (FETCH+ISSUE) + core latency + 1 (GAP).

Test Plan:
- Reset during WAIT (rst high 1 cycle) -> next cycle core_inputmode=IM_IDLE, busy=0, core_cmd=0, error=0.
- N_IN=4, start, in_valid always high -> four IM_LOAD write cycles:
  - waddr pairs (0,1),(2,3),(4,5),(6,7); wdata equal to the driven words.
  - FETCH follows with prog_addr=0.
- in_valid toggled 1,0,1,0 -> IM_IDLE on the idle cycles; counter advances only on accepted beats; still exactly 4 writes.
- Program {cmd A=0x01_10_20_30, END}, core model asserting finished 5 cycles after EXEC:
  - core_cmd=A during WAIT, exactly one GAP cycle with IM_IDLE, then prog_addr=1.
  - READ raddr 64..75 in pairs; 6 out_valid beats carrying the model's words; done on the 6th.
- Core model never finishes, TIMEOUT=100 -> error=1 and IDLE after 100 WAIT cycles; next start clears error.
- PC_SIZE=2, program without END -> error=1 after the GAP at pc=3, no READ cycles.

Source files
------------

// File: rtl/pairing_cmd_sequencer.sv
// Upstream sequencer for the pairing core: loads input coordinates, runs the
// command program from external memory, then streams result words back out.
module pairing_cmd_sequencer #(
    parameter int WORD_SIZE     = 256,
    parameter int RAM_ADDR_SIZE = 8,
    parameter int CMD_SIZE      = 32,
    parameter int IM_SIZE       = 2,
    parameter logic [IM_SIZE-1:0] IM_IDLE = IM_SIZE'(0),
    parameter logic [IM_SIZE-1:0] IM_LOAD = IM_SIZE'(1),
    parameter logic [IM_SIZE-1:0] IM_EXEC = IM_SIZE'(2),
    parameter logic [IM_SIZE-1:0] IM_REF  = IM_SIZE'(3),
    parameter int PC_SIZE       = 10,
    parameter int N_IN          = 4,
    parameter int IN_BASE       = 0,
    parameter int N_OUT         = 6,
    parameter int OUT_BASE      = 64,
    parameter int TIMEOUT       = 65535
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORD_SIZE-1:0]     in_data1,
    input  logic [WORD_SIZE-1:0]     in_data2,
    output logic [PC_SIZE-1:0]       prog_addr,
    input  logic [CMD_SIZE-1:0]      prog_data,
    output logic [IM_SIZE-1:0]       core_inputmode,
    output logic [CMD_SIZE-1:0]      core_cmd,
    output logic [RAM_ADDR_SIZE-1:0] core_waddr1,
    output logic [RAM_ADDR_SIZE-1:0] core_waddr2,
    output logic [WORD_SIZE-1:0]     core_wdata1,
    output logic [WORD_SIZE-1:0]     core_wdata2,
    output logic [RAM_ADDR_SIZE-1:0] core_raddr1,
    output logic [RAM_ADDR_SIZE-1:0] core_raddr2,
    input  logic [WORD_SIZE-1:0]     core_out1,
    input  logic [WORD_SIZE-1:0]     core_out2,
    input  logic                     core_finished,
    output logic                     out_valid,
    output logic [WORD_SIZE-1:0]     out_data1,
    output logic [WORD_SIZE-1:0]     out_data2
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FETCH, S_ISSUE, S_WAIT, S_GAP, S_READ, S_DONE
    } state_t;

    localparam int NMAX = (N_IN > N_OUT) ? N_IN : N_OUT;
    localparam int BW   = (NMAX > 1) ? $clog2(NMAX) : 1;
    localparam int WW   = $clog2(TIMEOUT + 1);

    localparam logic [BW-1:0]            IN_LAST   = BW'(N_IN - 1);
    localparam logic [BW-1:0]            OUT_LAST  = BW'(N_OUT - 1);
    localparam logic [WW-1:0]            WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [RAM_ADDR_SIZE-1:0] IN_BASE_A  = RAM_ADDR_SIZE'(IN_BASE);
    localparam logic [RAM_ADDR_SIZE-1:0] OUT_BASE_A = RAM_ADDR_SIZE'(OUT_BASE);
    localparam logic [RAM_ADDR_SIZE-1:0] ONE_A      = RAM_ADDR_SIZE'(1);

    state_t                  state_q;
    logic [PC_SIZE-1:0]      pc_q;
    logic [BW-1:0]           beat_q;
    logic [WW-1:0]           wait_q;
    logic [CMD_SIZE-1:0]     cmd_q;
    logic                    error_q;
    logic                    done_q;
    logic                    out_valid_q;
    logic [WORD_SIZE-1:0]    out1_q;
    logic [WORD_SIZE-1:0]    out2_q;

    logic                     accept;
    logic                     is_end;
    logic [RAM_ADDR_SIZE-1:0] beat_off;

    assign accept   = (state_q == S_LOAD) && in_valid;
    assign is_end   = &prog_data[CMD_SIZE-1:3*RAM_ADDR_SIZE];
    // Truncation to the address width gives the required modulo wrap.
    assign beat_off = RAM_ADDR_SIZE'({beat_q, 1'b0});

    assign busy      = (state_q != S_IDLE);
    assign in_ready  = (state_q == S_LOAD);
    assign prog_addr = pc_q;
    assign core_cmd  = cmd_q;
    assign error     = error_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_data1 = out1_q;
    assign out_data2 = out2_q;

    always_comb begin
        core_inputmode = IM_IDLE;
        core_waddr1    = '0;
        core_waddr2    = '0;
        core_wdata1    = '0;
        core_wdata2    = '0;
        core_raddr1    = '0;
        core_raddr2    = '0;
        unique case (state_q)
            S_LOAD: begin
                if (accept) begin
                    core_inputmode = IM_LOAD;
                    core_waddr1    = IN_BASE_A + beat_off;
                    core_waddr2    = IN_BASE_A + beat_off + ONE_A;
                    core_wdata1    = in_data1;
                    core_wdata2    = in_data2;
                end
            end
            S_WAIT: core_inputmode = IM_EXEC;
            S_READ: begin
                core_inputmode = IM_REF;
                core_raddr1    = OUT_BASE_A + beat_off;
                core_raddr2    = OUT_BASE_A + beat_off + ONE_A;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            beat_q      <= '0;
            wait_q      <= '0;
            cmd_q       <= '0;
            error_q     <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out1_q      <= '0;
            out2_q      <= '0;
        end else begin
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_LOAD;
                        error_q <= 1'b0;
                        pc_q    <= '0;
                        beat_q  <= '0;
                        wait_q  <= '0;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        if (beat_q == IN_LAST) begin
                            beat_q  <= '0;
                            state_q <= S_FETCH;
                        end else begin
                            beat_q <= beat_q + BW'(1);
                        end
                    end
                end
                S_FETCH: state_q <= S_ISSUE;
                S_ISSUE: begin
                    if (is_end) begin
                        state_q <= S_READ;
                    end else begin
                        cmd_q   <= prog_data;
                        wait_q  <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Finished is tested first so it wins on the last allowed cycle.
                    if (core_finished) begin
                        cmd_q   <= '0;
                        state_q <= S_GAP;
                    end else if (wait_q == WAIT_LAST) begin
                        cmd_q   <= '0;
                        error_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        wait_q <= wait_q + WW'(1);
                    end
                end
                S_GAP: begin
                    pc_q <= pc_q + PC_SIZE'(1);
                    if (pc_q == '1) begin
                        error_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_FETCH;
                    end
                end
                S_READ: begin
                    out_valid_q <= 1'b1;
                    out1_q      <= core_out1;
                    out2_q      <= core_out2;
                    if (beat_q == OUT_LAST) begin
                        beat_q  <= '0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        beat_q <= beat_q + BW'(1);
                    end
                end
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pairing_cmd_sequencer.sv
// Directed bench for pairing_cmd_sequencer with a small core / program-memory model.
module tb_pairing_cmd_sequencer;

    localparam logic [31:0] CMD_A   = 32'h0110_2030;
    localparam logic [31:0] CMD_END = 32'hFF00_0000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         busy, done, error;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [255:0] in_data1 = '0, in_data2 = '0;
    logic [1:0]   prog_addr;
    logic [31:0]  prog_data = '0;
    logic [1:0]   core_inputmode;
    logic [31:0]  core_cmd;
    logic [7:0]   core_waddr1, core_waddr2, core_raddr1, core_raddr2;
    logic [255:0] core_wdata1, core_wdata2, core_out1, core_out2;
    logic         core_finished;
    logic         out_valid;
    logic [255:0] out_data1, out_data2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pairing_cmd_sequencer #(.PC_SIZE(2), .TIMEOUT(100)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
        .in_valid(in_valid), .in_ready(in_ready), .in_data1(in_data1), .in_data2(in_data2),
        .prog_addr(prog_addr), .prog_data(prog_data), .core_inputmode(core_inputmode),
        .core_cmd(core_cmd), .core_waddr1(core_waddr1), .core_waddr2(core_waddr2),
        .core_wdata1(core_wdata1), .core_wdata2(core_wdata2),
        .core_raddr1(core_raddr1), .core_raddr2(core_raddr2),
        .core_out1(core_out1), .core_out2(core_out2), .core_finished(core_finished),
        .out_valid(out_valid), .out_data1(out_data1), .out_data2(out_data2)
    );

    // Core model: finishes in the 5th EXEC cycle unless told to hang.
    logic hang = 1'b0;
    int   exec_cnt = 0;
    always @(posedge clk) exec_cnt <= (core_inputmode == 2'd2) ? exec_cnt + 1 : 0;
    assign core_finished = !hang && (core_inputmode == 2'd2) && (exec_cnt == 4);

    function automatic logic [255:0] coreword(input logic [7:0] a);
        return {8{24'hC0FFEE, a}};
    endfunction
    assign core_out1 = coreword(core_raddr1);
    assign core_out2 = coreword(core_raddr2);

    logic [31:0] prog_mem [4];
    always @(posedge clk) prog_data <= prog_mem[prog_addr];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic         v;
        logic [255:0] d1, d2;
        logic [7:0]   wa1;
        logic         ready;
        logic         wr;
    } vec_t;

    function automatic vec_t mk(input logic v, input int tag, input logic [7:0] wa1, input logic ready);
        vec_t r;
        logic [31:0] w;
        w = 32'hD100_0000 + 32'(tag);
        r.d1 = {8{w}};
        w = 32'hD200_0000 + 32'(tag);
        r.d2 = {8{w}};
        r.v = v;
        r.wa1 = wa1;
        r.ready = ready;
        r.wr = v && ready;
        return r;
    endfunction

    vec_t tbl [13];

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic load_all();
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data1 = {8{32'hAB00_0000 + 32'(b)}};
            in_data2 = {8{32'hCD00_0000 + 32'(b)}};
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, 256'(ok), 256'(1));
    endtask

    task automatic run_vec(input int i, output logic wrote);
        @(negedge clk);
        in_valid = tbl[i].v;
        in_data1 = tbl[i].d1;
        in_data2 = tbl[i].d2;
        #1;
        chk($sformatf("v%0d_mode", i), 256'(core_inputmode), 256'(tbl[i].wr ? 2'd1 : 2'd0));
        chk($sformatf("v%0d_waddr1", i), 256'(core_waddr1), 256'(tbl[i].wa1));
        chk($sformatf("v%0d_waddr2", i), 256'(core_waddr2), 256'(tbl[i].wr ? tbl[i].wa1 + 8'd1 : 8'd0));
        chk($sformatf("v%0d_wdata1", i), core_wdata1, tbl[i].wr ? tbl[i].d1 : '0);
        chk($sformatf("v%0d_wdata2", i), core_wdata2, tbl[i].wr ? tbl[i].d2 : '0);
        chk($sformatf("v%0d_in_ready", i), 256'(in_ready), 256'(tbl[i].ready));
        chk($sformatf("v%0d_prog_addr", i), 256'(prog_addr), 256'(0));
        chk($sformatf("v%0d_busy", i), 256'(busy), 256'(1));
        wrote = (core_inputmode == 2'd1);
    endtask

    initial begin
        int   wr_cnt, exec_n, ref_n;
        logic wrote, found, ok;
        logic [1:0]  em;
        logic [7:0]  ra;

        // Beats 0..3 back to back, then the FETCH cycle.
        tbl[0]  = mk(1, 1, 8'd0, 1);
        tbl[1]  = mk(1, 2, 8'd2, 1);
        tbl[2]  = mk(1, 3, 8'd4, 1);
        tbl[3]  = mk(1, 4, 8'd6, 1);
        tbl[4]  = mk(0, 5, 8'd0, 0);
        // in_valid toggling: idle cycles must not write nor advance the beat.
        tbl[5]  = mk(1, 6, 8'd0, 1);
        tbl[6]  = mk(0, 7, 8'd0, 1);
        tbl[7]  = mk(1, 8, 8'd2, 1);
        tbl[8]  = mk(0, 9, 8'd0, 1);
        tbl[9]  = mk(1, 10, 8'd4, 1);
        tbl[10] = mk(0, 11, 8'd0, 1);
        tbl[11] = mk(1, 12, 8'd6, 1);
        tbl[12] = mk(0, 13, 8'd0, 0);

        for (int i = 0; i < 4; i++) prog_mem[i] = CMD_END;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_mode", 256'(core_inputmode), 256'(0));
        chk("rst_cmd", 256'(core_cmd), 256'(0));
        chk("rst_error", 256'(error), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_in_ready", 256'(in_ready), 256'(0));
        chk("rst_prog_addr", 256'(prog_addr), 256'(0));
        rst = 1'b0;

        do_start();
        for (int i = 0; i < 5; i++) run_vec(i, wrote);
        in_valid = 1'b0;
        wait_idle("t1_idle", 40);

        do_start();
        wr_cnt = 0;
        for (int i = 5; i < 13; i++) begin
            run_vec(i, wrote);
            if (wrote) wr_cnt++;
        end
        in_valid = 1'b0;
        chk("t2_writes", 256'(wr_cnt), 256'(4));
        wait_idle("t2_idle", 40);

        // Program {A, END}; a stray start during WAIT must be ignored.
        prog_mem[0] = CMD_A;
        do_start();
        load_all();
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            start = (c == 3);
            #1;
            em = (c >= 2 && c <= 6) ? 2'd2 : (c >= 10 && c <= 15) ? 2'd3 : 2'd0;
            chk($sformatf("t3_mode_c%0d", c), 256'(core_inputmode), 256'(em));
            chk($sformatf("t3_cmd_c%0d", c), 256'(core_cmd), 256'((c >= 2 && c <= 6) ? CMD_A : 32'd0));
            chk($sformatf("t3_pc_c%0d", c), 256'(prog_addr), 256'((c <= 7) ? 2'd0 : 2'd1));
            chk($sformatf("t3_busy_c%0d", c), 256'(busy), 256'(c < 17));
            chk($sformatf("t3_done_c%0d", c), 256'(done), 256'(c == 16));
            chk($sformatf("t3_ovalid_c%0d", c), 256'(out_valid), 256'(c >= 11 && c <= 16));
            ra = (c >= 10 && c <= 15) ? 8'(64 + 2 * (c - 10)) : 8'd0;
            chk($sformatf("t3_raddr1_c%0d", c), 256'(core_raddr1), 256'(ra));
            chk($sformatf("t3_raddr2_c%0d", c), 256'(core_raddr2), 256'((c >= 10 && c <= 15) ? ra + 8'd1 : 8'd0));
            if (c >= 11 && c <= 16) begin
                ra = 8'(64 + 2 * (c - 11));
                chk($sformatf("t3_odata1_c%0d", c), out_data1, coreword(ra));
                chk($sformatf("t3_odata2_c%0d", c), out_data2, coreword(ra + 8'd1));
            end
        end
        start = 1'b0;

        // Hanging core: exactly 100 EXEC cycles, then error and IDLE.
        hang = 1'b1;
        do_start();
        load_all();
        exec_n = 0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (core_inputmode == 2'd2) exec_n++;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t4_idle", 256'(ok), 256'(1));
        chk("t4_exec_cycles", 256'(exec_n), 256'(100));
        chk("t4_error_set", 256'(error), 256'(1));
        chk("t4_cmd_cleared", 256'(core_cmd), 256'(0));
        hang = 1'b0;
        prog_mem[0] = CMD_END;
        do_start();
        @(negedge clk);
        #1;
        chk("t4_error_cleared", 256'(error), 256'(0));
        chk("t4_reload_ready", 256'(in_ready), 256'(1));
        load_all();
        wait_idle("t4_rerun_idle", 40);

        // Reset in the middle of WAIT.
        hang = 1'b1;
        prog_mem[0] = CMD_A;
        do_start();
        load_all();
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (core_inputmode == 2'd2) begin
                found = 1'b1;
                break;
            end
        end
        chk("t5_reached_wait", 256'(found), 256'(1));
        rst = 1'b1;
        #1;
        chk("t5_async_busy", 256'(busy), 256'(0));
        chk("t5_async_mode", 256'(core_inputmode), 256'(0));
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("t5_mode", 256'(core_inputmode), 256'(0));
        chk("t5_busy", 256'(busy), 256'(0));
        chk("t5_cmd", 256'(core_cmd), 256'(0));
        chk("t5_error", 256'(error), 256'(0));
        rst = 1'b0;
        hang = 1'b0;

        // No END in a 4-word program: overrun after the GAP at pc=3.
        for (int i = 0; i < 4; i++) prog_mem[i] = CMD_A;
        do_start();
        load_all();
        exec_n = 0;
        ref_n = 0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (core_inputmode == 2'd2) exec_n++;
            if (core_inputmode == 2'd3) ref_n++;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t6_idle", 256'(ok), 256'(1));
        chk("t6_error", 256'(error), 256'(1));
        chk("t6_exec_cycles", 256'(exec_n), 256'(20));
        chk("t6_read_cycles", 256'(ref_n), 256'(0));
        chk("t6_done", 256'(done), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
